wbc_sram: RTL and testbench

//  Wishbone classic responder: one crossbar slave port (cyc/stb/we/addr/data/sel) onto an on-chip word SRAM.

---
 rtl/wbc_sram_pkg.sv | 19 +
 rtl/wbc_sram_mem.sv | 34 +++
 rtl/wbc_sram.sv | 129 ++++++++++++
 tb/tb_wbc_sram.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbc_sram_pkg.sv
// Shared definitions for the Wishbone classic SRAM responder: FSM encoding,
// wait counter width and the request-decode helper.
package wbc_sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wbc_state_t;

    localparam int WAIT_W = 4;

    // A request is refused when it falls past the implemented words or writes a read-only array.
    function automatic logic req_is_bad(input logic [31:0] idx, input int unsigned depth,
                                        input logic readonly, input logic we);
        return (idx >= depth) || (readonly && we);
    endfunction

endpackage

// File: rtl/wbc_sram_mem.sv
// Word SRAM with synchronous byte-enabled write and synchronous registered read.
module wbc_sram_mem #(
    parameter int DW    = 32,
    parameter int SW    = DW / 8,
    parameter int DEPTH = 1024,
    parameter int MW    = 10
) (
    input  logic          i_clk,
    input  logic          i_rd_en,
    input  logic [MW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data,
    input  logic          i_wr_en,
    input  logic [MW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [SW-1:0] i_wr_sel
);

    logic [DW-1:0] mem [DEPTH];

    // Unselected lanes keep their old contents; the array itself is never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < SW; b++) begin
                if (i_wr_sel[b]) begin
                    mem[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
        if (i_rd_en) begin
            o_rd_data <= mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/wbc_sram.sv
// Wishbone classic slave port onto an on-chip word SRAM, with programmable
// wait states, byte-lane writes, error response and abort on cycle drop.
module wbc_sram
    import wbc_sram_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int SW          = DW / 8,
    parameter int DEPTH       = 1024,
    parameter int WIN_BITS    = 12,
    parameter int WAIT_STATES = 0,
    parameter int READONLY    = 0
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_cyc,
    input  logic          i_stb,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    input  logic [SW-1:0] i_sel,
    output logic          o_ack,
    output logic [DW-1:0] o_data,
    output logic          o_err
);

    localparam int LSB = $clog2(SW);
    localparam int MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wbc_state_t        state, next_state;
    logic [WAIT_W-1:0] wait_cnt;

    logic              req_we;
    logic [MW-1:0]     req_idx;
    logic [DW-1:0]     req_data;
    logic [SW-1:0]     req_sel;
    logic              req_bad;

    logic [31:0]       live_idx;
    logic              live_bad;
    logic              capture;
    logic              rd_en;
    logic [MW-1:0]     rd_addr;
    logic              wr_en;
    logic [DW-1:0]     rd_data;
    logic              unused_addr;

    assign live_idx    = 32'(i_addr[WIN_BITS-1:LSB]);
    assign live_bad    = req_is_bad(live_idx, DEPTH, READONLY != 0, i_we);
    assign capture     = (state == ST_IDLE) && i_cyc && i_stb;
    assign unused_addr = ^{i_addr[AW-1:WIN_BITS], i_addr[LSB-1:0]};

    // The read is launched on the edge that enters RESP, so its address comes
    // straight off the bus when there are no wait states.
    assign rd_addr = (state == ST_IDLE) ? live_idx[MW-1:0] : req_idx;
    assign rd_en   = (next_state == ST_RESP) && !((state == ST_IDLE) ? live_bad : req_bad);
    assign wr_en   = (state == ST_RESP) && req_we && !req_bad;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            req_we   <= 1'b0;
            req_idx  <= '0;
            req_data <= '0;
            req_sel  <= '0;
            req_bad  <= 1'b0;
        end else begin
            state <= next_state;
            if (capture) begin
                req_we   <= i_we;
                req_idx  <= live_idx[MW-1:0];
                req_data <= i_data;
                req_sel  <= i_sel;
                req_bad  <= live_bad;
                wait_cnt <= WAIT_W'(WAIT_STATES);
            end else if (state == ST_WAIT) begin
                wait_cnt <= i_cyc ? (wait_cnt - WAIT_W'(1)) : '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        o_ack      = 1'b0;
        o_err      = 1'b0;
        o_data     = '0;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    next_state = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!i_cyc) begin
                    next_state = ST_IDLE;
                end else if (wait_cnt == WAIT_W'(1)) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                next_state = ST_IDLE;
                o_err      = req_bad;
                o_ack      = !req_bad;
                if (!req_bad && !req_we) begin
                    o_data = rd_data;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    wbc_sram_mem #(
        .DW    (DW),
        .SW    (SW),
        .DEPTH (DEPTH),
        .MW    (MW)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .i_wr_en   (wr_en),
        .i_wr_addr (req_idx),
        .i_wr_data (req_data),
        .i_wr_sel  (req_sel)
    );

endmodule

// File: tb/tb_wbc_sram.sv
// Bench for wbc_sram: three configurations (no wait / 3 waits / read-only)
// checked against a transaction-level memory model.
module tb_wbc_sram;

    logic        clk;
    logic        reset_n;
    logic        cyc, stb, we;
    logic [31:0] addr, data;
    logic [3:0]  sel;
    int          cur;

    logic [2:0]  cyc_v, ack_v, err_v;
    logic [31:0] rdat_v [3];

    int checks = 0;
    int errors = 0;

    int ws_of  [3] = '{0, 3, 1};
    int win_of [3] = '{13, 13, 12};
    bit ro_of  [3] = '{1'b0, 1'b0, 1'b1};

    logic [31:0] mdl [3][1024];
    logic [3:0]  kb  [3][1024];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 3; k++) cyc_v[k] = cyc && (cur == k);
    end

    wbc_sram #(.WIN_BITS(13), .WAIT_STATES(0), .READONLY(0)) dut0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_cyc(cyc_v[0]), .i_stb(stb), .i_we(we),
        .i_addr(addr), .i_data(data), .i_sel(sel),
        .o_ack(ack_v[0]), .o_data(rdat_v[0]), .o_err(err_v[0]));

    wbc_sram #(.WIN_BITS(13), .WAIT_STATES(3), .READONLY(0)) dut3 (
        .i_clk(clk), .i_reset_n(reset_n), .i_cyc(cyc_v[1]), .i_stb(stb), .i_we(we),
        .i_addr(addr), .i_data(data), .i_sel(sel),
        .o_ack(ack_v[1]), .o_data(rdat_v[1]), .o_err(err_v[1]));

    wbc_sram #(.WIN_BITS(12), .WAIT_STATES(1), .READONLY(1)) dutro (
        .i_clk(clk), .i_reset_n(reset_n), .i_cyc(cyc_v[2]), .i_stb(stb), .i_we(we),
        .i_addr(addr), .i_data(data), .i_sel(sel),
        .o_ack(ack_v[2]), .o_data(rdat_v[2]), .o_err(err_v[2]));

    // Reference: word index from the window bits, refusal rule, per-byte merge.
    function automatic void mdl_apply(input int d, input bit w, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] s,
                                      output bit e_ack, output bit e_err,
                                      output logic [31:0] e_data, output logic [31:0] e_mask);
        int unsigned idx;
        idx    = (a % (32'd1 << win_of[d])) / 32'd4;
        e_err  = (idx >= 1024) || (ro_of[d] && w);
        e_ack  = !e_err;
        e_data = '0;
        e_mask = '1;
        if (e_ack && w) begin
            e_mask = '0;
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
                    kb[d][idx][b] = 1'b1;
                end
            end
        end else if (e_ack) begin
            e_data = mdl[d][idx];
            for (int b = 0; b < 4; b++) e_mask[8*b +: 8] = {8{kb[d][idx][b]}};
        end
    endfunction

    // Drives one transfer from IDLE and reports what came back; lat counts edges from capture.
    task automatic do_xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input bit scramble,
                           output bit g_ack, output bit g_err, output logic [31:0] g_data,
                           output int lat, output bit quiet);
        cur = d; cyc = 1'b1; stb = 1'b1; we = w; addr = a; data = wd; sel = s;
        g_ack = 1'b0; g_err = 1'b0; g_data = '0; lat = 0; quiet = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ack_v[d] || err_v[d]) begin
                g_ack = ack_v[d]; g_err = err_v[d]; g_data = rdat_v[d]; lat = i;
                break;
            end
            if (rdat_v[d] !== '0) quiet = 1'b0;
            if (scramble) begin
                we = 1'($urandom); addr = $urandom; data = $urandom; sel = 4'($urandom);
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cur = 0; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h100; data = '0; sel = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ack_v !== 3'b0 || err_v !== 3'b0 || rdat_v[0] !== '0 || rdat_v[1] !== '0 || rdat_v[2] !== '0) begin
                errors++;
                $display("[TB] FAIL reset_quiet: ack=%b err=%b data0=%h, want all zero", ack_v, err_v, rdat_v[0]);
            end
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack_v[0] !== 1'b1 || err_v[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_first_ack: ack=%b err=%b, want ack=1 err=0", ack_v[0], err_v[0]);
        end
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        bit ga, ge, q, ea, ee; logic [31:0] gd, ed, em; int lat;
        do_xfer(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, ga, ge, gd, lat, q);
        mdl_apply(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, ea, ee, ed, em);
        checks++;
        if (ga !== 1'b1 || ge !== 1'b0 || lat != 1) begin
            errors++;
            $display("[TB] FAIL wr_ack: ack=%b err=%b lat=%0d, want ack=1 err=0 lat=1", ga, ge, lat);
        end
        do_xfer(0, 1'b0, 32'h100, '0, 4'h0, 1'b0, ga, ge, gd, lat, q);
        checks++;
        if (ga !== 1'b1 || gd !== 32'hDEADBEEF || lat != 1) begin
            errors++;
            $display("[TB] FAIL rd_data: ack=%b data=%h lat=%0d, want ack=1 data=deadbeef lat=1", ga, gd, lat);
        end
    endtask

    task automatic test_byte_lanes();
        bit ga, ge, q, ea, ee; logic [31:0] gd, ed, em; int lat;
        do_xfer(0, 1'b1, 32'h100, 32'h11223344, 4'h5, 1'b0, ga, ge, gd, lat, q);
        mdl_apply(0, 1'b1, 32'h100, 32'h11223344, 4'h5, ea, ee, ed, em);
        do_xfer(0, 1'b0, 32'h100, '0, 4'h0, 1'b0, ga, ge, gd, lat, q);
        checks++;
        if (gd !== 32'hDE22BE44) begin
            errors++;
            $display("[TB] FAIL lane_merge: data=%h, want de22be44", gd);
        end
        do_xfer(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, 1'b0, ga, ge, gd, lat, q);
        mdl_apply(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, ea, ee, ed, em);
        checks++;
        if (ga !== 1'b1 || ge !== 1'b0) begin
            errors++;
            $display("[TB] FAIL sel_none_ack: ack=%b err=%b, want ack=1 err=0", ga, ge);
        end
        do_xfer(0, 1'b0, 32'hFFFF_E100, '0, 4'h0, 1'b0, ga, ge, gd, lat, q);
        checks++;
        if (ga !== 1'b1 || gd !== 32'hDE22BE44) begin
            errors++;
            $display("[TB] FAIL alias_read: ack=%b data=%h, want ack=1 data=de22be44", ga, gd);
        end
    endtask

    task automatic test_error();
        bit ga, ge, q, ea, ee; logic [31:0] gd, ed, em, base; int lat;
        do_xfer(0, 1'b0, 32'h1000, '0, 4'h0, 1'b0, ga, ge, gd, lat, q);
        checks++;
        if (ga !== 1'b0 || ge !== 1'b1 || gd !== '0 || lat != 1) begin
            errors++;
            $display("[TB] FAIL oow_read: ack=%b err=%b data=%h lat=%0d, want ack=0 err=1 data=0 lat=1", ga, ge, gd, lat);
        end
        do_xfer(0, 1'b1, 32'hABCD_1FFC, 32'h12345678, 4'hF, 1'b0, ga, ge, gd, lat, q);
        checks++;
        if (ga !== 1'b0 || ge !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oow_write: ack=%b err=%b, want ack=0 err=1", ga, ge);
        end
        do_xfer(2, 1'b0, 32'h080, '0, 4'h0, 1'b0, ga, ge, base, lat, q);
        checks++;
        if (ga !== 1'b1 || ge !== 1'b0 || lat != 2) begin
            errors++;
            $display("[TB] FAIL ro_read: ack=%b err=%b lat=%0d, want ack=1 err=0 lat=2", ga, ge, lat);
        end
        do_xfer(2, 1'b1, 32'h080, ~base, 4'hF, 1'b0, ga, ge, gd, lat, q);
        checks++;
        if (ga !== 1'b0 || ge !== 1'b1 || gd !== '0) begin
            errors++;
            $display("[TB] FAIL ro_write_err: ack=%b err=%b data=%h, want ack=0 err=1 data=0", ga, ge, gd);
        end
        do_xfer(2, 1'b0, 32'h080, '0, 4'h0, 1'b0, ga, ge, gd, lat, q);
        checks++;
        if (gd !== base) begin
            errors++;
            $display("[TB] FAIL ro_unchanged: data=%h, want %h", gd, base);
        end
    endtask

    task automatic test_wait_states();
        bit ga, ge, q, ea, ee; logic [31:0] gd, ed, em; int lat, n, edges;
        logic [31:0] ra [3];
        ra[0] = 32'h040; ra[1] = 32'h044; ra[2] = 32'h048;
        for (int i = 0; i < 3; i++) begin
            gd = $urandom;
            do_xfer(1, 1'b1, ra[i], gd, 4'hF, 1'b1, ga, ge, ed, lat, q);
            mdl_apply(1, 1'b1, ra[i], gd, 4'hF, ea, ee, ed, em);
            checks++;
            if (ga !== 1'b1 || lat != 4 || !q) begin
                errors++;
                $display("[TB] FAIL ws_write_lat: ack=%b lat=%0d quiet=%b, want ack=1 lat=4 quiet=1", ga, lat, q);
            end
        end
        cur = 1; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = ra[0]; n = 0; edges = 0;
        while (n < 3 && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (ack_v[1] || err_v[1]) begin
                mdl_apply(1, 1'b0, ra[n], '0, 4'h0, ea, ee, ed, em);
                checks++;
                if (edges != 4 + 5 * n || ack_v[1] !== 1'b1 || rdat_v[1] !== ed) begin
                    errors++;
                    $display("[TB] FAIL b2b_read%0d: edge=%0d ack=%b data=%h, want edge=%0d ack=1 data=%h",
                             n, edges, ack_v[1], rdat_v[1], 4 + 5 * n, ed);
                end
                n++;
                if (n < 3) addr = ra[n];
            end
        end
        cyc = 1'b0; stb = 1'b0;
        checks++;
        if (n != 3 || edges + 1 != 15) begin
            errors++;
            $display("[TB] FAIL b2b_total: reads=%0d cycles=%0d, want reads=3 cycles=15", n, edges + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit ga, ge, q, ea, ee, seen; logic [31:0] gd, ed, em; int lat;
        do_xfer(1, 1'b1, 32'h200, 32'hA5A5_0F0F, 4'hF, 1'b0, ga, ge, gd, lat, q);
        mdl_apply(1, 1'b1, 32'h200, 32'hA5A5_0F0F, 4'hF, ea, ee, ed, em);
        cur = 1; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h200; data = 32'h5A5A_F0F0; sel = 4'hF;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack_v[1] || err_v[1]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL abort_silent: response seen=1, want 0");
        end
        do_xfer(1, 1'b0, 32'h200, '0, 4'h0, 1'b0, ga, ge, gd, lat, q);
        mdl_apply(1, 1'b0, 32'h200, '0, 4'h0, ea, ee, ed, em);
        checks++;
        if (ga !== 1'b1 || gd !== ed) begin
            errors++;
            $display("[TB] FAIL abort_unchanged: ack=%b data=%h, want ack=1 data=%h", ga, gd, ed);
        end
    endtask

    task automatic test_reset_mid();
        bit ga, ge, q, ea, ee, seen; logic [31:0] gd, ed, em; int lat;
        do_xfer(1, 1'b1, 32'h300, 32'h0BAD_CAFE, 4'hF, 1'b0, ga, ge, gd, lat, q);
        mdl_apply(1, 1'b1, 32'h300, 32'h0BAD_CAFE, 4'hF, ea, ee, ed, em);
        cur = 1; cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 32'h300; data = 32'h1111_2222; sel = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) reset_n = 1'b1;
            @(posedge clk); #1;
            if (ack_v[1] || err_v[1]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL reset_mid_silent: response seen=1, want 0");
        end
        do_xfer(1, 1'b0, 32'h300, '0, 4'h0, 1'b0, ga, ge, gd, lat, q);
        mdl_apply(1, 1'b0, 32'h300, '0, 4'h0, ea, ee, ed, em);
        checks++;
        if (gd !== 32'h0BAD_CAFE || gd !== ed) begin
            errors++;
            $display("[TB] FAIL reset_mid_unchanged: data=%h, want 0badcafe", gd);
        end
    endtask

    task automatic test_random();
        bit ga, ge, q, ea, ee, w; logic [31:0] gd, ed, em, a, wd, r; logic [3:0] s; int lat;
        for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 60; t++) begin
                r  = $urandom;
                w  = 1'($urandom);
                wd = $urandom;
                s  = 4'($urandom);
                a  = r & ~((32'd1 << win_of[d]) - 32'd1);
                if (win_of[d] == 13 && $urandom_range(0, 7) == 0)
                    a = a | 32'h1000 | (wd & 32'hFFF);
                else
                    a = a | (32'($urandom_range(0, 15)) << 2) | (r & 32'h3);
                do_xfer(d, w, a, wd, s, 1'b1, ga, ge, gd, lat, q);
                mdl_apply(d, w, a, wd, s, ea, ee, ed, em);
                checks++;
                if (ga !== ea || ge !== ee || lat != ws_of[d] + 1 || !q) begin
                    errors++;
                    $display("[TB] FAIL rand_resp dut%0d addr=%h we=%b: ack=%b err=%b lat=%0d quiet=%b, want ack=%b err=%b lat=%0d quiet=1",
                             d, a, w, ga, ge, lat, q, ea, ee, ws_of[d] + 1);
                end
                checks++;
                if ((gd & em) !== (ed & em)) begin
                    errors++;
                    $display("[TB] FAIL rand_data dut%0d addr=%h: data=%h, want %h (mask %h)", d, a, gd, ed, em);
                end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 1024; i++) begin
                mdl[d][i] = '0;
                kb[d][i]  = 4'h0;
            end
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_error();
        test_wait_states();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
